aibndaux_crdet_seq: RTL and testbench
=====================================

Name: aibndaux_crdet_seq

Overview:
- Parametrised next-generation aux crete-detect / POR block for the AIB slave aux domain.
- Monitors NUM_CH raw crete-detect inputs and applies synchronisation, a programmable debounce and a per-channel override to each.
- Combines the channels in ALL or ANY mode.
- Sequences the far-side POR (o_dn_por) through a hold-off state machine, releasing it only after detection has stayed stable for POR_HOLD cycles.

Parameters:
- NUM_CH, 4: number of crete-detect channels (>=1).
- DBNC_W, 8: width of the debounce threshold and of each per-channel debounce counter.
- POR_HOLD, 16: cycles that detection must stay qualified before POR release (>=1).
- HOLD_W, 8: width of the hold counter (2^HOLD_W > POR_HOLD).

Ports:
- i_osc_clk  input  1  aux oscillator clock; the only clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_crdet_raw  input  NUM_CH  raw crete-detect per channel, asynchronous to i_osc_clk.
- i_crdet_ovrd  input  NUM_CH  per-channel detect override (forces detect = 1).
- i_dbnc_cyc  input  DBNC_W  debounce threshold, quasi-static.
- i_mode_any  input  1  1 = ANY channel qualifies, 0 = ALL channels required.
- i_dn_por  input  1  upstream POR, 1 = asserted.
- o_crdet  output  NUM_CH  debounced detect OR override.
- o_crdet_agg  output  1  aggregate detect.
- o_dn_por  output  1  far-side POR, 1 = asserted; registered.
- o_lost  output  1  one-cycle pulse on loss of detect while active.
- o_state  output  2  FSM state: WAIT=0, HOLD=1, ACTIVE=2, LOST=3.

Behaviour:
- Reset (async assert, sync release on i_osc_clk). While i_rst_n = 0:
  - sync flops, debounced state and debounce counters = 0;
  - o_dn_por = 1, o_lost = 0, o_state = WAIT, hold counter = 0.
- Synchroniser: each i_crdet_raw bit passes through a 2-flop synchroniser (reset 0), giving s[i].
- Debounce, per channel:
  - Keep a debounced bit d[i] and a saturating counter c[i].
  - If s[i] == d[i], c[i] <= 0.
  - Otherwise, if c[i] >= i_dbnc_cyc then d[i] <= s[i] and c[i] <= 0; else c[i] <= c[i] + 1.
  - Net effect: d[i] follows s[i] only after s[i] differs for i_dbnc_cyc+1 consecutive cycles.
  - Latency from a raw edge to d[i] is 2 + i_dbnc_cyc + 1 cycles; with i_dbnc_cyc = 0 this is 3 cycles.
  - A glitch shorter than the threshold leaves d[i] unchanged and clears c[i].
  - c[i] saturates at all-ones and never wraps.
  - A change of i_dbnc_cyc mid-count takes effect on the next compare.
- Override: o_crdet[i] = d[i] | i_crdet_ovrd[i], combinational.
- Aggregate: o_crdet_agg = i_mode_any ? OR(o_crdet) : AND(o_crdet), combinational.
- FSM, registered:
  - WAIT: if o_crdet_agg & !i_dn_por, go to HOLD and load hold counter = POR_HOLD-1.
  - HOLD: if !o_crdet_agg or i_dn_por, go to WAIT. Otherwise, if the counter == 0 go to ACTIVE, else decrement. HOLD therefore lasts exactly POR_HOLD cycles when uninterrupted.
  - ACTIVE:
    - if i_dn_por, go to WAIT with no o_lost pulse; i_dn_por takes priority when both conditions occur in the same cycle;
    - else if !o_crdet_agg, go to LOST.
  - LOST: unconditionally go to WAIT on the next cycle.
- o_dn_por is registered: 0 only while o_state == ACTIVE, 1 in every other state. It deasserts in the same cycle o_state becomes ACTIVE.
- o_lost is registered: 1 for exactly the one cycle o_state == LOST.
- Asynchronous reset mid-sequence immediately forces WAIT and o_dn_por = 1, from any state.

Test Plan:
1. Reset, then NUM_CH=4, ALL mode, i_dbnc_cyc=3, all raw bits rise together, i_dn_por=0 -> o_crdet=4'hF at 6 cycles after the edge; HOLD for 16 cycles; o_dn_por falls 16 cycles after HOLD entry; o_state=2.
2. Glitch: one raw bit pulses low for 3 cycles while ACTIVE, i_dbnc_cyc=3 -> o_crdet unchanged, FSM stays ACTIVE, o_lost stays 0.
3. Loss: channel 2 drops for 10 cycles while ACTIVE -> o_crdet[2]=0 after 6 cycles; o_state goes LOST for 1 cycle with o_lost=1; o_state then goes WAIT with o_dn_por=1.
4. ANY mode with only channel 0 raw high; then separately, ALL mode with channels 1-3 low but i_crdet_ovrd=4'b1110 and channel 0 high -> in both cases o_crdet_agg=1 and the sequence reaches ACTIVE.
5. Abort in HOLD: i_dn_por pulses high at hold cycle 8 -> o_state returns to WAIT and o_dn_por stays 1. After i_dn_por drops, HOLD restarts and runs the full 16 cycles.
6. Reset and priority corners:
   - i_rst_n asserted while ACTIVE -> o_dn_por=1 and o_state=0 with no clock edge needed.
   - i_dn_por and loss of detect in the same ACTIVE cycle -> go to WAIT with o_lost=0.
   - i_dbnc_cyc=0 -> 3-cycle latency.

Source files
------------

// File: rtl/aibndaux_crdet_seq_if.sv
// Status/control bundle for the aux crete-detect / POR sequencer.
interface aibndaux_crdet_seq_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DBNC_W = 8
);
    logic [NUM_CH-1:0] i_crdet_raw;
    logic [NUM_CH-1:0] i_crdet_ovrd;
    logic [DBNC_W-1:0] i_dbnc_cyc;
    logic              i_mode_any;
    logic              i_dn_por;
    logic [NUM_CH-1:0] o_crdet;
    logic              o_crdet_agg;
    logic              o_dn_por;
    logic              o_lost;
    logic [1:0]        o_state;

    modport master (
        output i_crdet_raw, i_crdet_ovrd, i_dbnc_cyc, i_mode_any, i_dn_por,
        input  o_crdet, o_crdet_agg, o_dn_por, o_lost, o_state
    );

    modport slave (
        input  i_crdet_raw, i_crdet_ovrd, i_dbnc_cyc, i_mode_any, i_dn_por,
        output o_crdet, o_crdet_agg, o_dn_por, o_lost, o_state
    );
endinterface

// File: rtl/aibndaux_crdet_seq.sv
// Aux-domain crete-detect qualifier: sync, debounce, override, aggregate,
// then far-side POR release sequencing with a hold-off counter.
module aibndaux_crdet_seq #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DBNC_W   = 8,
    parameter int unsigned POR_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                 i_osc_clk,
    input  logic                 i_rst_n,
    aibndaux_crdet_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    logic [NUM_CH-1:0] sync_q1;
    logic [NUM_CH-1:0] sync_q2;
    logic [NUM_CH-1:0] dbnc_q;
    logic [DBNC_W-1:0] cnt_q [NUM_CH];
    logic [NUM_CH-1:0] crdet_c;
    logic              agg_c;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              dn_por_q;
    logic              lost_q;

    // Two-flop synchroniser for the asynchronous raw detects
    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.i_crdet_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Per-channel debounce: flip only after the threshold compare succeeds
    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbnc_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (sync_q2[i] == dbnc_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= bus.i_dbnc_cyc) begin
                    dbnc_q[i] <= sync_q2[i];
                    cnt_q[i]  <= '0;
                end else if (cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + DBNC_W'(1);
                end
            end
        end
    end

    assign crdet_c = dbnc_q | bus.i_crdet_ovrd;
    assign agg_c   = bus.i_mode_any ? (|crdet_c) : (&crdet_c);

    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_WAIT;
            hold_q   <= '0;
            dn_por_q <= 1'b1;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            dn_por_q <= (state_d != ST_ACTIVE);
            lost_q   <= (state_d == ST_LOST);
        end
    end

    // Upstream POR always wins over loss of detect
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_WAIT: begin
                if (agg_c && !bus.i_dn_por) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_W'(POR_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (!agg_c || bus.i_dn_por) begin
                    state_d = ST_WAIT;
                end else if (hold_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (bus.i_dn_por) begin
                    state_d = ST_WAIT;
                end else if (!agg_c) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign bus.o_crdet     = crdet_c;
    assign bus.o_crdet_agg = agg_c;
    assign bus.o_dn_por    = dn_por_q;
    assign bus.o_lost      = lost_q;
    assign bus.o_state     = state_q;

endmodule

// File: tb/tb_aibndaux_crdet_seq.sv
// Scoreboard bench for aibndaux_crdet_seq: expectations are queued with the
// cycle they are due and checked on the falling edge.
module tb_aibndaux_crdet_seq;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DBNC_W = 8;

    localparam int SIG_CRDET = 0;
    localparam int SIG_AGG   = 1;
    localparam int SIG_POR   = 2;
    localparam int SIG_LOST  = 3;
    localparam int SIG_STATE = 4;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_bad;
    exp_t sb[$];

    aibndaux_crdet_seq_if #(.NUM_CH(NUM_CH), .DBNC_W(DBNC_W)) bus ();

    aibndaux_crdet_seq #(
        .NUM_CH(NUM_CH), .DBNC_W(DBNC_W), .POR_HOLD(16), .HOLD_W(8)
    ) dut (
        .i_osc_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [7:0] probe(input int sig);
        case (sig)
            SIG_CRDET: return 8'(bus.o_crdet);
            SIG_AGG:   return 8'(bus.o_crdet_agg);
            SIG_POR:   return 8'(bus.o_dn_por);
            SIG_LOST:  return 8'(bus.o_lost);
            SIG_STATE: return 8'(bus.o_state);
            default:   return 8'h00;
        endcase
    endfunction

    task automatic exp_at(input int dly, input int sig, input logic [7:0] val, input string tag);
        exp_t e;
        e.cyc = cyc + dly;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance n cycles; pop and compare everything due at each falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    chk(sb[i].tag, 32'(probe(sb[i].sig)), 32'(sb[i].val));
                    sb.delete(i);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && sb.size() != 0; k++) tick(1);
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic set_defaults();
        bus.i_crdet_raw  = '0;
        bus.i_crdet_ovrd = '0;
        bus.i_dbnc_cyc   = 8'd3;
        bus.i_mode_any   = 1'b0;
        bus.i_dn_por     = 1'b0;
    endtask

    task automatic do_reset();
        tick(1);
        rst_n = 1'b0;
        set_defaults();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        set_defaults();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_por",   32'(bus.o_dn_por), 32'd1);
        chk("rst_state", 32'(bus.o_state),  32'd0);
        chk("rst_lost",  32'(bus.o_lost),   32'd0);
        chk("rst_crdet", 32'(bus.o_crdet),  32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // 1: all channels rise together, ALL mode, threshold 3
        bus.i_crdet_raw = 4'hF;
        exp_at(5,  SIG_CRDET, 8'h0, "t1_crdet_early");
        exp_at(6,  SIG_CRDET, 8'hF, "t1_crdet");
        exp_at(5,  SIG_AGG,   8'h0, "t1_agg_early");
        exp_at(6,  SIG_AGG,   8'h1, "t1_agg");
        exp_at(6,  SIG_STATE, 8'h0, "t1_wait");
        exp_at(7,  SIG_STATE, 8'h1, "t1_hold_entry");
        exp_at(22, SIG_STATE, 8'h1, "t1_hold_last");
        exp_at(22, SIG_POR,   8'h1, "t1_por_held");
        exp_at(23, SIG_STATE, 8'h2, "t1_active");
        exp_at(23, SIG_POR,   8'h0, "t1_por_release");
        exp_at(23, SIG_LOST,  8'h0, "t1_lost");
        drain("t1_drain");

        // 2: 3-cycle glitch on channel 0 is filtered at threshold 3
        bus.i_crdet_raw = 4'hE;
        for (int k = 1; k <= 12; k += 2) begin
            exp_at(k, SIG_STATE, 8'h2, "t2_state");
            exp_at(k, SIG_CRDET, 8'hF, "t2_crdet");
            exp_at(k, SIG_LOST,  8'h0, "t2_lost");
        end
        tick(3);
        bus.i_crdet_raw = 4'hF;
        drain("t2_drain");

        // 3: channel 2 drops for 10 cycles while ACTIVE
        bus.i_crdet_raw = 4'hB;
        exp_at(5,  SIG_CRDET, 8'hF, "t3_crdet_early");
        exp_at(6,  SIG_CRDET, 8'hB, "t3_crdet");
        exp_at(6,  SIG_STATE, 8'h2, "t3_still_active");
        exp_at(7,  SIG_STATE, 8'h3, "t3_lost_state");
        exp_at(7,  SIG_LOST,  8'h1, "t3_lost_pulse");
        exp_at(7,  SIG_POR,   8'h1, "t3_por_lost");
        exp_at(8,  SIG_STATE, 8'h0, "t3_wait");
        exp_at(8,  SIG_LOST,  8'h0, "t3_lost_end");
        exp_at(8,  SIG_POR,   8'h1, "t3_por_wait");
        exp_at(10, SIG_STATE, 8'h0, "t3_wait_hold");
        tick(10);
        bus.i_crdet_raw = 4'hF;
        drain("t3_drain");

        // 4a: ANY mode with only channel 0
        do_reset();
        bus.i_mode_any  = 1'b1;
        bus.i_crdet_raw = 4'h1;
        exp_at(5,  SIG_AGG,   8'h0, "t4a_agg_early");
        exp_at(6,  SIG_AGG,   8'h1, "t4a_agg");
        exp_at(6,  SIG_CRDET, 8'h1, "t4a_crdet");
        exp_at(23, SIG_STATE, 8'h2, "t4a_active");
        exp_at(23, SIG_POR,   8'h0, "t4a_por");
        drain("t4a_drain");

        // 4b: ALL mode completed by override on channels 1-3
        do_reset();
        bus.i_crdet_ovrd = 4'b1110;
        bus.i_crdet_raw  = 4'h1;
        exp_at(1,  SIG_CRDET, 8'hE, "t4b_ovrd_only");
        exp_at(5,  SIG_AGG,   8'h0, "t4b_agg_early");
        exp_at(6,  SIG_CRDET, 8'hF, "t4b_crdet");
        exp_at(6,  SIG_AGG,   8'h1, "t4b_agg");
        exp_at(22, SIG_STATE, 8'h1, "t4b_hold");
        exp_at(23, SIG_STATE, 8'h2, "t4b_active");
        exp_at(23, SIG_POR,   8'h0, "t4b_por");
        drain("t4b_drain");

        // 5: upstream POR pulse at hold cycle 8 restarts the full hold
        do_reset();
        bus.i_crdet_raw = 4'hF;
        exp_at(7,  SIG_STATE, 8'h1, "t5_hold1");
        exp_at(14, SIG_STATE, 8'h1, "t5_hold8");
        exp_at(15, SIG_STATE, 8'h0, "t5_abort");
        exp_at(15, SIG_POR,   8'h1, "t5_por_abort");
        exp_at(16, SIG_STATE, 8'h1, "t5_rehold");
        exp_at(31, SIG_STATE, 8'h1, "t5_rehold_last");
        exp_at(31, SIG_POR,   8'h1, "t5_por_rehold");
        exp_at(32, SIG_STATE, 8'h2, "t5_active");
        exp_at(32, SIG_POR,   8'h0, "t5_por_release");
        tick(14);
        bus.i_dn_por = 1'b1;
        tick(1);
        bus.i_dn_por = 1'b0;
        drain("t5_drain");

        // 6a: asynchronous reset while ACTIVE, no clock edge
        chk("t6a_pre_por", 32'(bus.o_dn_por), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6a_por",   32'(bus.o_dn_por), 32'd1);
        chk("t6a_state", 32'(bus.o_state),  32'd0);

        // 6b: upstream POR and loss of detect in the same ACTIVE cycle
        do_reset();
        bus.i_crdet_raw = 4'hF;
        exp_at(23, SIG_STATE, 8'h2, "t6b_active");
        drain("t6b_drain0");
        bus.i_crdet_raw = 4'hB;
        exp_at(6, SIG_AGG,   8'h0, "t6b_agg_drop");
        exp_at(6, SIG_STATE, 8'h2, "t6b_pre");
        tick(6);
        bus.i_dn_por = 1'b1;
        exp_at(1, SIG_STATE, 8'h0, "t6b_wait");
        exp_at(1, SIG_LOST,  8'h0, "t6b_no_lost");
        exp_at(1, SIG_POR,   8'h1, "t6b_por");
        exp_at(2, SIG_STATE, 8'h0, "t6b_wait2");
        exp_at(2, SIG_LOST,  8'h0, "t6b_no_lost2");
        drain("t6b_drain1");

        // 6c: zero threshold gives 3-cycle latency
        do_reset();
        bus.i_dbnc_cyc  = 8'd0;
        bus.i_crdet_raw = 4'hF;
        exp_at(2, SIG_CRDET, 8'h0, "t6c_crdet_early");
        exp_at(3, SIG_CRDET, 8'hF, "t6c_crdet");
        exp_at(4, SIG_STATE, 8'h1, "t6c_hold");
        drain("t6c_drain");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
